// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sizes, register map and types for the sprite table writer
package sprite_pkg;
    localparam int NUM_SPRITES = 20;
    localparam int ENTRY_W = 24;
    localparam int BUS_W = 512;
    localparam logic [4:0] REG_CTRL = 5'd20;
    localparam logic [4:0] REG_FRAME = 5'd21;
    localparam int CTRL_PENDING = 0;
    localparam int CTRL_AUTO = 1;
    typedef enum logic [1:0] {IDLE, ARMED, COMMIT} state_t;
    typedef logic [ENTRY_W-1:0] entry_t;
endpackage

// File: rtl/sprite_table_writer_if.sv
// sprite_table_writer_if: Avalon-MM slave bus between the HPS bridge and the sprite table writer
interface sprite_table_writer_if;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [4:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master (output chipselect, write, read, address, writedata, input readdata);
    modport slave (input chipselect, write, read, address, writedata, output readdata);
endinterface

// File: rtl/vsync_edge_detect.sv
// vsync_edge_detect: falling-edge detector on vertical sync; history resets high so no edge follows reset
module vsync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic vs,
    output logic vs_fall
);
    logic vs_d_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) vs_d_q <= 1'b1;
        else vs_d_q <= vs;
    end
    assign vs_fall = vs_d_q & ~vs;
endmodule

// File: rtl/sprite_table_writer.sv
// sprite_table_writer: shadow sprite table written over Avalon, copied to the display bus on vsync fall
module sprite_table_writer
    import sprite_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    sprite_table_writer_if.slave avs,
    input  logic                 VGA_VS,
    output logic [BUS_W-1:0]     gl_input,
    output logic                 gl_write
);
    state_t           state_q, state_d;
    entry_t           shadow_q [NUM_SPRITES];
    entry_t           shadow_d [NUM_SPRITES];
    logic [BUS_W-1:0] gl_input_q, gl_input_d, packed_tbl;
    logic             gl_write_q, gl_write_d;
    logic             pending_q, pending_d, auto_q, auto_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             vs_fall, wr, rd, ctrl_wr, commit;

    vsync_edge_detect u_vs (.clk(clk), .reset(reset), .vs(VGA_VS), .vs_fall(vs_fall));

    assign wr = avs.chipselect & avs.write;
    assign rd = avs.chipselect & avs.read;
    assign ctrl_wr = wr && avs.address == REG_CTRL;
    assign commit = state_q == ARMED && vs_fall;

    always_comb begin
        packed_tbl = '0;
        for (int i = 0; i < NUM_SPRITES; i++) packed_tbl[i*ENTRY_W +: ENTRY_W] = shadow_q[i];
    end

    // a CTRL write landing on the commit cycle re-arms for the next frame
    always_comb begin
        shadow_d = shadow_q;
        if (wr && avs.address < 5'(NUM_SPRITES)) shadow_d[avs.address] = avs.writedata[ENTRY_W-1:0];
        pending_d = (ctrl_wr && avs.writedata[CTRL_PENDING]) || (pending_q && !commit);
        auto_d = ctrl_wr ? avs.writedata[CTRL_AUTO] : auto_q;
        frame_cnt_d = (wr && avs.address == REG_FRAME) ? '0 : frame_cnt_q + 16'(vs_fall);
        gl_input_d = commit ? packed_tbl : gl_input_q;
        gl_write_d = commit;
        readdata_d = !rd ? readdata_q :
                     avs.address < 5'(NUM_SPRITES) ? 32'(shadow_q[avs.address]) :
                     avs.address == REG_CTRL ? {30'b0, auto_q, pending_q} :
                     avs.address == REG_FRAME ? {16'b0, frame_cnt_q} : '0;
    end

    always_comb begin
        state_d = state_q;
        state_d = commit ? COMMIT : (pending_d || auto_d) ? ARMED : IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shadow_q <= '{default: '0};
            gl_input_q <= '0;
            gl_write_q <= 1'b0;
            pending_q <= 1'b0;
            auto_q <= 1'b0;
            frame_cnt_q <= '0;
            readdata_q <= '0;
        end else begin
            state_q <= state_d;
            shadow_q <= shadow_d;
            gl_input_q <= gl_input_d;
            gl_write_q <= gl_write_d;
            pending_q <= pending_d;
            auto_q <= auto_d;
            frame_cnt_q <= frame_cnt_d;
            readdata_q <= readdata_d;
        end
    end

    assign gl_input = gl_input_q;
    assign gl_write = gl_write_q;
    assign avs.readdata = readdata_q;
endmodule

// File: tb/tb_sprite_table_writer.sv
// tb_sprite_table_writer: directed table, corner sequences and random traffic against a frame-level model
module tb_sprite_table_writer;
    logic         clk = 1'b0;
    logic         reset;
    logic         vga_vs;
    logic [511:0] gl_input;
    logic         gl_write;
    int           nvec = 0;
    int           nfail = 0;

    sprite_table_writer_if bus ();

    sprite_table_writer dut (
        .clk(clk), .reset(reset), .avs(bus), .VGA_VS(vga_vs),
        .gl_input(gl_input), .gl_write(gl_write)
    );

    always #5 clk = ~clk;

    logic [23:0]  m_sh [32];
    logic         m_pend, m_auto, m_vsp, m_gw;
    logic [15:0]  m_fc;
    logic [511:0] m_gi;
    logic [31:0]  m_rd;

    typedef struct {
        logic        w;
        logic        r;
        logic [4:0]  a;
        logic [31:0] d;
        logic        v;
        logic        gw;
        logic        crd;
        logic [31:0] rdv;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string n, input logic [511:0] act, input logic [511:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < 32; i++) m_sh[i] = '0;
        m_pend = 0; m_auto = 0; m_vsp = 1; m_gw = 0; m_fc = '0; m_gi = '0; m_rd = '0;
    endtask

    function automatic logic [511:0] table_image();
        logic [511:0] p = '0;
        for (int i = 0; i < 20; i++) p[i*24 +: 24] = m_sh[i];
        return p;
    endfunction

    // one bus cycle: drive, predict the frame-level effect, then compare after the edge
    task automatic cyc(input logic w, input logic r, input logic [4:0] a, input logic [31:0] d, input logic v);
        logic vf, com;
        logic [31:0] rv;
        bus.chipselect = w | r; bus.write = w; bus.read = r; bus.address = a; bus.writedata = d;
        vga_vs = v;
        vf = m_vsp & ~v;
        com = vf & (m_pend | m_auto);
        rv = a < 20 ? {8'b0, m_sh[a]} : a == 20 ? {30'b0, m_auto, m_pend} : a == 21 ? {16'b0, m_fc} : 32'b0;
        if (r) m_rd = rv;
        if (com) begin m_gi = table_image(); m_pend = 0; end
        m_gw = com;
        if (w && a == 20) begin
            if (d[0]) m_pend = 1;
            m_auto = d[1];
        end
        m_fc = (w && a == 21) ? 16'd0 : m_fc + 16'(vf);
        if (w && a < 20) m_sh[a] = d[23:0];
        m_vsp = v;
        @(posedge clk); #1;
        chk("gl_write", gl_write, m_gw);
        chk("gl_input", gl_input, m_gi);
        chk("readdata", bus.readdata, m_rd);
    endtask

    initial begin
        logic [511:0] saved;
        logic [23:0]  val;
        logic         v;
        logic [1:0]   op;
        logic [4:0]   a;
        tbl[0] = '{1, 0, 5'd0,  32'h00ABCDEF, 1, 0, 0, 32'h0};
        tbl[1] = '{1, 0, 5'd19, 32'h00123456, 1, 0, 0, 32'h0};
        tbl[2] = '{1, 0, 5'd20, 32'h1,        1, 0, 0, 32'h0};
        tbl[3] = '{0, 0, 5'd0,  32'h0,        1, 0, 0, 32'h0};
        tbl[4] = '{0, 0, 5'd0,  32'h0,        0, 1, 0, 32'h0};
        tbl[5] = '{0, 1, 5'd20, 32'h0,        0, 0, 1, 32'h0};
        tbl[6] = '{1, 0, 5'd3,  32'hFFFFFFFF, 1, 0, 0, 32'h0};
        tbl[7] = '{0, 1, 5'd3,  32'h0,        1, 0, 1, 32'h00FFFFFF};
        tbl[8] = '{0, 1, 5'd25, 32'h0,        1, 0, 1, 32'h0};
        tbl[9] = '{0, 1, 5'd0,  32'h0,        1, 0, 1, 32'h00ABCDEF};

        reset = 0; vga_vs = 1;
        bus.chipselect = 0; bus.write = 0; bus.read = 0; bus.address = '0; bus.writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gl_input", gl_input, 512'b0);
        chk("rst_gl_write", gl_write, 1'b0);
        chk("rst_readdata", bus.readdata, 32'b0);
        mreset();
        reset = 1;

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].v);
            chk("tbl_gw", gl_write, tbl[i].gw);
            if (tbl[i].crd) chk("tbl_rd", bus.readdata, tbl[i].rdv);
        end
        chk("slot0", gl_input[23:0], 24'hABCDEF);
        chk("slot19", gl_input[479:456], 24'h123456);
        chk("unused_hi", gl_input[511:480], 32'b0);

        saved = gl_input;
        cyc(1, 0, 5'd1, 32'h00555555, 1);
        cyc(1, 0, 5'd21, 32'h0, 1);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 5'd0, 32'h0, 0);
            chk("nocommit_gw", gl_write, 1'b0);
            cyc(0, 0, 5'd0, 32'h0, 0);
            cyc(0, 0, 5'd0, 32'h0, 1);
            cyc(0, 0, 5'd0, 32'h0, 1);
        end
        cyc(0, 1, 5'd21, 32'h0, 1);
        chk("frame_cnt3", bus.readdata, 32'd3);
        chk("nocommit_hold", gl_input, saved);

        cyc(1, 0, 5'd20, 32'h2, 1);
        for (int f = 0; f < 3; f++) begin
            val = 24'($urandom);
            cyc(1, 0, 5'd5, {8'hA5, val}, 1);
            cyc(0, 0, 5'd0, 32'h0, 0);
            chk("auto_gw", gl_write, 1'b1);
            chk("auto_slot5", gl_input[143:120], val);
            cyc(0, 0, 5'd0, 32'h0, 0);
            chk("auto_gw_low", gl_write, 1'b0);
            cyc(0, 0, 5'd0, 32'h0, 1);
        end
        cyc(1, 0, 5'd20, 32'h0, 1);

        cyc(1, 0, 5'd2, 32'h00111111, 1);
        cyc(1, 0, 5'd20, 32'h1, 0);
        chk("coll_nopulse", gl_write, 1'b0);
        cyc(0, 0, 5'd0, 32'h0, 0);
        cyc(0, 0, 5'd0, 32'h0, 1);
        cyc(1, 0, 5'd2, 32'h00222222, 0);
        chk("coll_pulse", gl_write, 1'b1);
        chk("coll_old_slot2", gl_input[71:48], 24'h111111);
        cyc(0, 0, 5'd0, 32'h0, 1);
        cyc(1, 0, 5'd21, 32'h0, 0);
        cyc(0, 1, 5'd21, 32'h0, 0);
        chk("frame_clear_wins", bus.readdata, 32'd0);
        cyc(1, 0, 5'd20, 32'h1, 1);
        cyc(0, 0, 5'd0, 32'h0, 1);
        cyc(0, 0, 5'd0, 32'h0, 0);
        chk("coll_new_slot2", gl_input[71:48], 24'h222222);

        cyc(1, 0, 5'd20, 32'h1, 1);
        cyc(0, 0, 5'd0, 32'h0, 1);
        bus.chipselect = 0; bus.write = 0; bus.read = 0;
        vga_vs = 0;
        reset = 0;
        #1;
        chk("midrst_gl_input", gl_input, 512'b0);
        chk("midrst_gl_write", gl_write, 1'b0);
        mreset();
        #1 reset = 1;
        cyc(0, 1, 5'd20, 32'h0, 0);
        chk("midrst_ctrl", bus.readdata, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 5'd0, 32'h0, 0);
            chk("midrst_nopulse", gl_write, 1'b0);
        end

        v = 1;
        for (int k = 0; k < 400; k++) begin
            v = ($urandom_range(0, 4) == 0) ? ~v : v;
            op = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? 5'(20 + $urandom_range(0, 3)) : 5'($urandom_range(0, 23));
            cyc(op[0], op[1], a, $urandom, v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/sprite_table_writer.md
Name: sprite_table_writer

Overview:
- Avalon-MM slave: software writes sprite entries into a shadow table, then requests a commit.
- At the next VGA vertical-sync falling edge, the block copies the shadow table onto the packed `gl_input` bus and pulses `gl_write` for one cycle, so the sprite attribute table updates tear-free.
- It is the writer end of the sprite table interface. It sits between the HPS bridge and the VGA/sprite display top.

Parameters:
- NUM_SPRITES, 20, number of sprite entries; NUM_SPRITES*ENTRY_W must be <= BUS_W.
- ENTRY_W, 24, bits per sprite entry; the entry contents are opaque to this block.
- BUS_W, 512, width of the packed output bus.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous reset, active-low.
- chipselect  in  1  Avalon select.
- write  in  1  Avalon write strobe; acted on only when chipselect=1.
- read  in  1  Avalon read strobe; acted on only when chipselect=1.
- address  in  5  word address.
- writedata  in  32  Avalon write data.
- readdata  out  32  registered read data.
- VGA_VS  in  1  vertical sync, active-low, same clock domain.
- gl_input  out  BUS_W  packed sprite table; entry i occupies [ENTRY_W*i+ENTRY_W-1 : ENTRY_W*i]; unused high bits are 0.
- gl_write  out  1  one-cycle commit strobe to the display.

Behaviour:
- Reset (asynchronous, reset=0) clears the following to 0:
  - shadow[0..NUM_SPRITES-1], gl_input, gl_write, readdata;
  - pending, auto, frame_cnt[15:0];
  - state returns to IDLE; vs_d is set to 1, so no spurious edge is seen after reset.
- Register map, writes:
  - 0..NUM_SPRITES-1: shadow[address] <= writedata[ENTRY_W-1:0]; upper bits ignored.
  - 20 CTRL: bit0=1 sets pending (a write of 0 has no effect on pending); bit1 sets auto (sticky, written every time).
  - 21 FRAME: any write clears frame_cnt.
  - Any other address: write ignored.
- Register map, reads:
  - 0..19: zero-extended shadow entry.
  - 20: {30'b0, auto, pending}.
  - 21: {16'b0, frame_cnt}.
  - Any other address: 0.
- Read latency: 1 cycle. readdata is updated on the clock after read&chipselect and holds otherwise.
- Edge detect: vs_d <= VGA_VS every cycle; vs_fall = vs_d & ~VGA_VS.
- FSM states:
  - IDLE: pending=0 and auto=0.
  - ARMED: pending=1 or auto=1.
  - COMMIT: one cycle.
- FSM transitions:
  - IDLE -> ARMED when pending or auto becomes set.
  - ARMED -> COMMIT on vs_fall.
  - COMMIT -> ARMED if auto=1, else -> IDLE.
- Commit timing:
  - If vs_fall occurs in cycle t while ARMED, then at the end of cycle t: gl_input <= packed shadow, pending <= 0.
  - gl_write=1 during cycle t+1 only.
  - gl_input holds its value until the next commit.
- frame_cnt increments (mod 2^16) on every vs_fall, regardless of state.
- Simultaneous events:
  - CTRL commit write in the same cycle as vs_fall: the edge is evaluated against the pre-write state, so a commit from IDLE waits for the next frame.
  - Shadow write in the same cycle as a commit copy: the copy uses the pre-write shadow value; the new value appears on the following commit.
  - FRAME clear in the same cycle as vs_fall: the clear wins (result 0).
- Reset mid-pending drops the commit; gl_input returns to 0 and no gl_write pulse is produced.

Decomposition:
- Package sprite_pkg holds:
  - NUM_SPRITES, ENTRY_W, BUS_W;
  - register address constants REG_CTRL=20, REG_FRAME=21;
  - CTRL bit indices;
  - the FSM state enum;
  - the entry typedef logic [ENTRY_W-1:0].
- One sub-module: vsync_edge_detect, providing vs_d and vs_fall with async active-low reset to 1.

Test Plan:
- Reset check: assert reset=0 mid-operation -> gl_input=0, gl_write=0; a read of address 20 returns 0; after release, a VGA_VS that is already 0 produces no commit.
- Basic commit:
  - Stimulus: write shadow[0]=24'hABCDEF and shadow[19]=24'h123456, then write CTRL=1, then drive VGA_VS 1->0.
  - Response: gl_write is high for exactly one cycle, the cycle after the edge; gl_input[23:0]=ABCDEF, gl_input[479:456]=123456, gl_input[511:480]=0; a read of address 20 returns 0.
- No commit: write shadow entries only, then run 3 vsync edges -> gl_write is never asserted, gl_input is unchanged, and a read of address 21 returns 3.
- Auto mode: write CTRL=2, change shadow[5] between frames -> gl_write pulses on every edge, and gl_input slot 5 tracks the shadow value one frame later.
- Collision:
  - Stimulus: write CTRL=1 on the vs_fall cycle from IDLE.
  - Response: no pulse on that edge; a pulse occurs on the next edge. Also, a shadow[2] write on the commit cycle leaves the old slot-2 value on gl_input.
- Readback: write 32'hFFFFFFFF to address 3 -> a read of address 3 returns 32'h00FFFFFF with 1-cycle latency; a read of address 25 returns 0.
